// File: rtl/fifo722gmii.sv
// fifo722gmii: pops 72-bit {valid,byte}x8 words from a standard-read FIFO and
// serialises them onto GMII TX with inter-frame gap pacing and underrun signalling.
module fifo722gmii #(
    parameter logic [3:0] Gap = 4'h9
) (
    input  logic        gmii_tx_clk,
    input  logic        sys_rst,
    input  logic [71:0] dout,
    input  logic        empty,
    output logic        rd_en,
    output logic        rd_clk,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic [7:0]  gmii_txd,
    output logic        underrun
);
    typedef enum logic [2:0] {IDLE, LOAD, SEND, ERR, IFG} state_t;
    state_t      state, state_nx;
    logic [71:0] word, word_nx;
    logic [2:0]  lane, lane_nx;
    logic [3:0]  gap_cnt, gap_nx;
    logic        frame_active, active_nx;
    logic        pf, pf_nx;
    logic        rd_req;
    logic        en_nx, er_nx, ur_nx;
    logic [7:0]  txd_nx;
    logic [8:0]  cur;
    logic        lane_valid, frame_end;

    assign rd_clk     = gmii_tx_clk;
    assign cur        = word[9*lane +: 9];
    assign lane_valid = cur[8];
    assign frame_end  = frame_active && !lane_valid;
    // a read issued the same cycle reset is sampled would be lost, so suppress it
    assign rd_en      = rd_req && !sys_rst;

    always_comb begin
        state_nx  = state;
        word_nx   = word;
        lane_nx   = lane;
        gap_nx    = gap_cnt;
        active_nx = frame_active;
        pf_nx     = pf;
        rd_req    = 1'b0;
        en_nx     = 1'b0;
        er_nx     = 1'b0;
        ur_nx     = 1'b0;
        txd_nx    = 8'h00;
        case (state)
            IDLE: begin
                rd_req   = !empty;
                state_nx = empty ? IDLE : LOAD;
            end
            LOAD: begin
                word_nx   = dout;
                lane_nx   = 3'd0;
                active_nx = 1'b0;
                pf_nx     = 1'b0;
                state_nx  = SEND;
            end
            SEND: begin
                en_nx     = lane_valid;
                txd_nx    = lane_valid ? cur[7:0] : 8'h00;
                active_nx = frame_active || lane_valid;
                lane_nx   = lane + 3'd1;
                // fetch the next word one lane early so it lands exactly after lane 7
                if (lane == 3'd6 && !frame_end && word[71] && !empty) begin
                    rd_req = 1'b1;
                    pf_nx  = 1'b1;
                end
                if (frame_end) begin
                    state_nx = (Gap == 4'd0) ? IDLE : IFG;
                    gap_nx   = Gap - 4'd1;
                end else if (lane == 3'd7) begin
                    pf_nx    = 1'b0;
                    word_nx  = pf ? dout : word;
                    state_nx = pf ? SEND : (lane_valid ? ERR : IDLE);
                end
            end
            ERR: begin
                en_nx    = 1'b1;
                er_nx    = 1'b1;
                ur_nx    = 1'b1;
                state_nx = (Gap == 4'd0) ? IDLE : IFG;
                gap_nx   = Gap - 4'd1;
            end
            IFG: begin
                state_nx = (gap_cnt == 4'd0) ? IDLE : IFG;
                gap_nx   = gap_cnt - 4'd1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge gmii_tx_clk) begin
        if (sys_rst) begin
            state        <= IDLE;
            word         <= '0;
            lane         <= 3'd0;
            gap_cnt      <= 4'd0;
            frame_active <= 1'b0;
            pf           <= 1'b0;
            gmii_tx_en   <= 1'b0;
            gmii_tx_er   <= 1'b0;
            gmii_txd     <= 8'h00;
            underrun     <= 1'b0;
        end else begin
            state        <= state_nx;
            word         <= word_nx;
            lane         <= lane_nx;
            gap_cnt      <= gap_nx;
            frame_active <= active_nx;
            pf           <= pf_nx;
            gmii_tx_en   <= en_nx;
            gmii_tx_er   <= er_nx;
            gmii_txd     <= txd_nx;
            underrun     <= ur_nx;
        end
    end
endmodule

// File: tb/tb_fifo722gmii.sv
// tb_fifo722gmii: FIFO model plus byte scoreboard for the GMII serialiser;
// each transmitted byte is popped from the expected queue filled at stimulus time.
`timescale 1ns/1ps
module tb_fifo722gmii;
    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [71:0] dout = '0;
    logic        empty = 1'b1;
    logic        rd_en, rd_clk, gmii_tx_en, gmii_tx_er, underrun;
    logic [7:0]  gmii_txd;
    int          tests = 0, fails = 0, tx_bytes = 0, rd_cnt = 0;
    logic [71:0] fq[$];
    logic [7:0]  exp_q[$];
    bit          en_log[$], er_log[$], ur_log[$], rd_log[$];
    logic [7:0]  txd_log[$];
    bit          pop_pending = 1'b0;

    always #4 clk = ~clk;

    fifo722gmii dut (
        .gmii_tx_clk(clk), .sys_rst(sys_rst), .dout(dout), .empty(empty),
        .rd_en(rd_en), .rd_clk(rd_clk), .gmii_tx_en(gmii_tx_en),
        .gmii_tx_er(gmii_tx_er), .gmii_txd(gmii_txd), .underrun(underrun)
    );

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running, required to finish");
        $fatal(1);
    end

    // one clock: FIFO responds to last cycle's read, then outputs are sampled
    task automatic tick;
        logic [7:0] e;
        @(negedge clk);
        if (pop_pending) begin
            dout = (fq.size() > 0) ? fq.pop_front() : 'x;
            pop_pending = 1'b0;
        end
        empty = (fq.size() == 0);
        #1;
        if (rd_en === 1'b1) begin
            tests++;
            rd_cnt++;
            if (empty) begin
                fails++;
                $display("FAIL rd_while_empty: rd_en=1 empty=%b, required no read while empty", empty);
            end
        end
        pop_pending = (rd_en === 1'b1);
        if (gmii_tx_en === 1'b1 && gmii_tx_er === 1'b0) begin
            tests++;
            tx_bytes++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL txd_extra: got %02h, required no byte", gmii_txd);
            end else begin
                e = exp_q.pop_front();
                if (gmii_txd !== e) begin
                    fails++;
                    $display("FAIL txd: got %02h, required %02h", gmii_txd, e);
                end
            end
        end
        en_log.push_back(gmii_tx_en === 1'b1);
        er_log.push_back(gmii_tx_er === 1'b1);
        ur_log.push_back(underrun === 1'b1);
        rd_log.push_back(rd_en === 1'b1);
        txd_log.push_back(gmii_txd);
    endtask

    task automatic clear_logs;
        en_log.delete(); er_log.delete(); ur_log.delete(); rd_log.delete(); txd_log.delete();
        rd_cnt = 0;
        tx_bytes = 0;
    endtask

    task automatic push_frame(input int len, input logic [7:0] base, input bit term);
        logic [71:0] w;
        for (int i = 0; i < len; i += 8) begin
            w = '0;
            for (int k = 0; k < 8; k++)
                if (i + k < len) begin
                    w[9*k +: 9] = {1'b1, 8'(base + i + k)};
                    exp_q.push_back(8'(base + i + k));
                end
            fq.push_back(w);
        end
        if (term && len % 8 == 0) fq.push_back('0);
    endtask

    task automatic drain(input int extra);
        int n = 0;
        while ((exp_q.size() != 0 || fq.size() != 0) && n < 1000) begin
            tick();
            n++;
        end
        tests++;
        if (exp_q.size() != 0 || fq.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d bytes %0d words left, required 0", exp_q.size(), fq.size());
        end
        repeat (extra) tick();
    endtask

    function automatic int first_en(input int from);
        for (int i = from; i < en_log.size(); i++) if (en_log[i]) return i;
        return -1;
    endfunction

    function automatic int first_rd();
        for (int i = 0; i < rd_log.size(); i++) if (rd_log[i]) return i;
        return -1;
    endfunction

    function automatic int run_len(input int from);
        int n = 0;
        if (from < 0) return 0;
        for (int i = from; i < en_log.size() && en_log[i]; i++) n++;
        return n;
    endfunction

    function automatic int count_q(input int which);
        int n = 0;
        for (int i = 0; i < en_log.size(); i++)
            n += (which == 0) ? int'(en_log[i]) : (which == 1) ? int'(er_log[i]) : int'(ur_log[i]);
        return n;
    endfunction

    task automatic test_reset;
        push_frame(8, 8'hF0, 1'b1);
        sys_rst = 1'b1;
        repeat (3) tick();
        tests++; if (rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en: got %b, required 0", rd_en); end
        tests++; if (gmii_tx_en !== 1'b0) begin fails++; $display("FAIL reset_tx_en: got %b, required 0", gmii_tx_en); end
        tests++; if (gmii_tx_er !== 1'b0) begin fails++; $display("FAIL reset_tx_er: got %b, required 0", gmii_tx_er); end
        tests++; if (gmii_txd !== 8'h00) begin fails++; $display("FAIL reset_txd: got %02h, required 00", gmii_txd); end
        tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun: got %b, required 0", underrun); end
        sys_rst = 1'b0;
        drain(20);
    endtask

    task automatic test_stream;
        int f, r;
        clear_logs();
        push_frame(64, 8'h00, 1'b1);
        drain(20);
        f = first_en(0);
        r = first_rd();
        tests++; if (f - r != 3) begin fails++; $display("FAIL stream_latency: got %0d, required 3", f - r); end
        tests++; if (run_len(f) != 64) begin fails++; $display("FAIL stream_run: got %0d, required 64", run_len(f)); end
        tests++; if (count_q(0) != 64) begin fails++; $display("FAIL stream_en_total: got %0d, required 64", count_q(0)); end
        tests++; if (rd_cnt != 9) begin fails++; $display("FAIL stream_reads: got %0d, required 9", rd_cnt); end
        tests++; if (count_q(1) != 0) begin fails++; $display("FAIL stream_tx_er: got %0d, required 0", count_q(1)); end
    endtask

    task automatic test_back_to_back;
        int f1, l1, f2, l2;
        clear_logs();
        push_frame(60, 8'h40, 1'b1);
        push_frame(60, 8'h80, 1'b1);
        drain(20);
        f1 = first_en(0);
        l1 = run_len(f1);
        f2 = first_en(f1 + l1);
        l2 = run_len(f2);
        tests++; if (l1 != 60) begin fails++; $display("FAIL b2b_len1: got %0d, required 60", l1); end
        tests++; if (l2 != 60) begin fails++; $display("FAIL b2b_len2: got %0d, required 60", l2); end
        tests++; if (f2 - (f1 + l1) != 12) begin fails++; $display("FAIL b2b_gap: got %0d, required 12", f2 - (f1 + l1)); end
    endtask

    task automatic test_underrun;
        int f, e;
        clear_logs();
        push_frame(16, 8'hC0, 1'b0);
        drain(20);
        f = first_en(0);
        e = f + 16;
        tests++; if (run_len(f) != 17) begin fails++; $display("FAIL ur_run: got %0d, required 17", run_len(f)); end
        tests++;
        if (f < 0 || e >= en_log.size()) begin
            fails++;
            $display("FAIL ur_err_cycle: index %0d missing, required present", e);
        end else if (!er_log[e] || !ur_log[e] || txd_log[e] !== 8'h00) begin
            fails++;
            $display("FAIL ur_err_cycle: er=%b ur=%b txd=%02h, required er=1 ur=1 txd=00", er_log[e], ur_log[e], txd_log[e]);
        end
        tests++; if (count_q(1) != 1) begin fails++; $display("FAIL ur_er_total: got %0d, required 1", count_q(1)); end
        tests++; if (count_q(2) != 1) begin fails++; $display("FAIL ur_pulse_total: got %0d, required 1", count_q(2)); end
        tests++;
        if (first_en(e + 1) != -1 || en_log.size() < e + 13) begin
            fails++;
            $display("FAIL ur_idle_after: next en at %0d log %0d, required none for 12 cycles", first_en(e + 1), en_log.size());
        end
    endtask

    task automatic test_lead_invalid;
        logic [71:0] w;
        int f, r;
        clear_logs();
        w = '0;
        for (int k = 3; k < 8; k++) begin
            w[9*k +: 9] = {1'b1, 8'(8'hA1 + k - 3)};
            exp_q.push_back(8'(8'hA1 + k - 3));
        end
        fq.push_back(w);
        fq.push_back('0);
        drain(20);
        f = first_en(0);
        r = first_rd();
        tests++; if (f - r != 6) begin fails++; $display("FAIL lead_offset: got %0d, required 6", f - r); end
        tests++; if (run_len(f) != 5) begin fails++; $display("FAIL lead_run: got %0d, required 5", run_len(f)); end
    endtask

    task automatic test_reset_midframe;
        int n = 0;
        clear_logs();
        push_frame(64, 8'h10, 1'b1);
        while (tx_bytes < 20 && n < 500) begin
            tick();
            n++;
        end
        tests++; if (tx_bytes != 20) begin fails++; $display("FAIL mid_reach20: got %0d bytes, required 20", tx_bytes); end
        sys_rst = 1'b1;
        exp_q.delete();
        fq.delete();
        tick();
        tests++; if (gmii_tx_en !== 1'b0) begin fails++; $display("FAIL mid_tx_en: got %b, required 0", gmii_tx_en); end
        tests++; if (rd_en !== 1'b0) begin fails++; $display("FAIL mid_rd_en: got %b, required 0", rd_en); end
        tests++; if (gmii_tx_er !== 1'b0) begin fails++; $display("FAIL mid_tx_er: got %b, required 0", gmii_tx_er); end
        repeat (2) tick();
        sys_rst = 1'b0;
        pop_pending = 1'b0;
        tick();
        clear_logs();
        push_frame(24, 8'h60, 1'b1);
        drain(20);
        tests++; if (run_len(first_en(0)) != 24) begin fails++; $display("FAIL mid_next_run: got %0d, required 24", run_len(first_en(0))); end
        tests++; if (rd_cnt != 4) begin fails++; $display("FAIL mid_next_reads: got %0d, required 4", rd_cnt); end
        tests++; if (count_q(1) != 0) begin fails++; $display("FAIL mid_next_er: got %0d, required 0", count_q(1)); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_underrun();
        test_lead_invalid();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
